// File: rtl/lisa_qspi_fetch_ctrl_if.sv
// Core request port and QSPI arbiter client port of the fetch controller.
// master = core/arbiter side, slave = the controller.
interface lisa_qspi_fetch_ctrl_if #(
  parameter int CHIP_SELECTS = 2
);
  logic                    req_valid;
  logic [23:0]             req_addr;
  logic                    req_we;
  logic [15:0]             req_wdata;
  logic [1:0]              req_wstrb;
  logic                    req_ready;
  logic [15:0]             req_rdata;
  logic                    flush;
  logic [CHIP_SELECTS-1:0] cfg_ce_ctrl;
  logic [23:0]             q_addr;
  logic [15:0]             q_wdata;
  logic [1:0]              q_wstrb;
  logic [3:0]              q_xfer_len;
  logic [CHIP_SELECTS-1:0] q_ce_ctrl;
  logic                    q_valid;
  logic                    q_ready;
  logic                    q_ready_ack;
  logic                    q_xfer_done;
  logic [15:0]             q_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb, flush, cfg_ce_ctrl,
           q_ready, q_xfer_done, q_rdata,
    input  req_ready, req_rdata, q_addr, q_wdata, q_wstrb, q_xfer_len, q_ce_ctrl,
           q_valid, q_ready_ack
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb, flush, cfg_ce_ctrl,
           q_ready, q_xfer_done, q_rdata,
    output req_ready, req_rdata, q_addr, q_wdata, q_wstrb, q_xfer_len, q_ce_ctrl,
           q_valid, q_ready_ack
  );
endinterface

// File: rtl/lisa_qspi_fetch_ctrl.sv
// QSPI fetch controller: one 4-word line buffer in front of the QSPI arbiter,
// reads fill whole lines, writes go straight through and patch a hit line.
module lisa_qspi_fetch_ctrl #(
  parameter int CHIP_SELECTS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  lisa_qspi_fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    line_valid;
  logic [21:0]             tag;
  logic [15:0]             line_buf [4];
  logic [1:0]              wcnt;
  logic                    ack_pend;
  logic                    fill_full;
  logic                    flush_seen;

  logic                    q_valid_r;
  logic [23:0]             q_addr_r;
  logic [15:0]             q_wdata_r;
  logic [1:0]              q_wstrb_r;
  logic [3:0]              q_len_r;
  logic [CHIP_SELECTS-1:0] q_ce_r;
  logic                    q_ack_r;
  logic                    req_ready_r;
  logic [15:0]             req_rdata_r;

  logic tag_hit, word_cnt, last_word;
  logic start_fill, start_write, rd_hit, fill_ok, fill_retry, write_done;
  logic [15:0] rd_word;

  assign tag_hit   = line_valid && (tag == bus.req_addr[23:2]) && !bus.flush;
  assign word_cnt  = q_valid_r && bus.q_ready && !ack_pend;
  // fill_full remembers that wcnt has already wrapped after the fourth word
  assign last_word = fill_full || (word_cnt && (wcnt == 2'd3));
  assign rd_word   = (word_cnt && (wcnt == bus.req_addr[1:0])) ? bus.q_rdata
                                                               : line_buf[bus.req_addr[1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_fill  = 1'b0;
    start_write = 1'b0;
    rd_hit      = 1'b0;
    fill_ok     = 1'b0;
    fill_retry  = 1'b0;
    write_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_we) begin
            start_write = 1'b1;
            state_nxt   = WRITE;
          end else if (tag_hit) begin
            rd_hit    = 1'b1;
            state_nxt = RESP;
          end else begin
            start_fill = 1'b1;
            state_nxt  = FILL;
          end
        end
      end
      FILL: begin
        if (q_valid_r && bus.q_xfer_done) begin
          if (last_word) begin
            fill_ok   = 1'b1;
            state_nxt = RESP;
          end else begin
            fill_retry = 1'b1;
          end
        end
      end
      WRITE: begin
        if (q_valid_r && bus.q_xfer_done) begin
          write_done = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid  <= 1'b0;
      tag         <= '0;
      wcnt        <= '0;
      ack_pend    <= 1'b0;
      fill_full   <= 1'b0;
      flush_seen  <= 1'b0;
      q_valid_r   <= 1'b0;
      q_addr_r    <= '0;
      q_wdata_r   <= '0;
      q_wstrb_r   <= '0;
      q_len_r     <= '0;
      q_ce_r      <= '0;
      q_ack_r     <= 1'b0;
      req_ready_r <= 1'b0;
      req_rdata_r <= '0;
    end else begin
      q_ack_r     <= word_cnt;
      ack_pend    <= word_cnt;
      req_ready_r <= 1'b0;
      req_rdata_r <= '0;
      if (state == FILL && word_cnt) begin
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'd3) fill_full <= 1'b1;
      end
      if (state == FILL && bus.flush) flush_seen <= 1'b1;
      if (start_fill) begin
        q_valid_r  <= 1'b1;
        q_addr_r   <= {bus.req_addr[23:2], 2'b00};
        q_len_r    <= 4'd4;
        q_wstrb_r  <= '0;
        q_wdata_r  <= '0;
        q_ce_r     <= bus.cfg_ce_ctrl;
        wcnt       <= '0;
        fill_full  <= 1'b0;
        flush_seen <= 1'b0;
        line_valid <= 1'b0;
      end
      if (start_write) begin
        q_valid_r <= 1'b1;
        q_addr_r  <= bus.req_addr;
        q_len_r   <= 4'd1;
        q_wstrb_r <= bus.req_wstrb;
        q_wdata_r <= bus.req_wdata;
        q_ce_r    <= bus.cfg_ce_ctrl;
      end
      // a short fill leaves FILL idle for one cycle, then re-raises the same request
      if (state == FILL && !q_valid_r) begin
        q_valid_r <= 1'b1;
        q_ce_r    <= bus.cfg_ce_ctrl;
      end
      if (rd_hit) begin
        req_ready_r <= 1'b1;
        req_rdata_r <= line_buf[bus.req_addr[1:0]];
      end
      if (fill_ok) begin
        q_valid_r   <= 1'b0;
        tag         <= bus.req_addr[23:2];
        line_valid  <= !flush_seen;
        req_ready_r <= 1'b1;
        req_rdata_r <= rd_word;
      end
      if (fill_retry) begin
        q_valid_r <= 1'b0;
        wcnt      <= '0;
        fill_full <= 1'b0;
      end
      if (write_done) begin
        q_valid_r   <= 1'b0;
        req_ready_r <= 1'b1;
        req_rdata_r <= '0;
      end
      if (bus.flush) line_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && word_cnt) line_buf[wcnt] <= bus.q_rdata;
    if (write_done && line_valid && (tag == bus.req_addr[23:2])) begin
      if (bus.req_wstrb[0]) line_buf[bus.req_addr[1:0]][7:0]  <= bus.req_wdata[7:0];
      if (bus.req_wstrb[1]) line_buf[bus.req_addr[1:0]][15:8] <= bus.req_wdata[15:8];
    end
  end

  assign bus.q_valid     = q_valid_r;
  assign bus.q_addr      = q_addr_r;
  assign bus.q_wdata     = q_wdata_r;
  assign bus.q_wstrb     = q_wstrb_r;
  assign bus.q_xfer_len  = q_len_r;
  assign bus.q_ce_ctrl   = q_ce_r;
  assign bus.q_ready_ack = q_ack_r;
  assign bus.req_ready   = req_ready_r;
  assign bus.req_rdata   = req_rdata_r;

endmodule

// File: doc/lisa_qspi_fetch_ctrl.md
LISA_QSPI_FETCH_CTRL -- requirements
Module: lisa_qspi_fetch_ctrl

Interface
REQ-001 Parameter: CHIP_SELECTS, default 2, width of the chip-enable vector driven to the QSPI arbiter client port.
REQ-002 Clocking: one clock, clk; reset rst, asynchronous, active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: req_valid  input  1  core request; held with its fields stable until req_ready.
REQ-006 Port: req_addr  input  24  16-bit-word address.
REQ-007 Port: req_we  input  1  1=write, 0=read.
REQ-008 Port: req_wdata  input  16  write data.
REQ-009 Port: req_wstrb  input  2  byte enables for a write.
REQ-010 Port: req_ready  output  1  one-cycle completion pulse.
REQ-011 Port: req_rdata  output  16  read data; valid only while req_ready is high.
REQ-012 Port: flush  input  1  invalidates the line buffer.
REQ-013 Port: cfg_ce_ctrl  input  CHIP_SELECTS  chip-enable value forwarded on q_ce_ctrl.
REQ-014 Port: q_addr  output 24; q_wdata  output 16; q_wstrb  output 2; q_xfer_len  output 4; q_ce_ctrl  output CHIP_SELECTS -- transfer fields of the arbiter client port.
REQ-015 Port: q_valid  output  1  transfer request.
REQ-016 Port: q_ready  input  1  one word is available or accepted.
REQ-017 Port: q_ready_ack  output  1  acknowledge of q_ready.
REQ-018 Port: q_xfer_done  input  1  whole transfer complete.
REQ-019 Port: q_rdata  input  16  read word, valid with q_ready.

Function
REQ-020 Line buffer: 4 x 16-bit words, 22-bit tag (address bits 23:2), and a line_valid bit.
REQ-021 The FSM has the states IDLE, FILL, WRITE and RESP; it uses a 2-bit word counter wcnt and a registered flag ack_pend.
REQ-022 In IDLE, a read that hits (line_valid, tag equal to req_addr[23:2], flush low) produces req_ready with buf[req_addr[1:0]] on the next cycle; it never touches the q_ port.
REQ-023 In IDLE, a read that misses goes to FILL with q_addr={req_addr[23:2],2'b00}, q_xfer_len=4, q_wstrb=0, q_valid=1 and wcnt=0.
REQ-024 In IDLE, a write goes to WRITE with q_addr=req_addr, q_xfer_len=1, q_wdata=req_wdata, q_wstrb=req_wstrb and q_valid=1.
REQ-025 q_valid and all q_ transfer fields are registered and stay constant from the cycle q_valid rises until the cycle after q_xfer_done is sampled, when q_valid returns to 0.
REQ-026 When q_ready is sampled high with ack_pend low, the block asserts q_ready_ack for exactly the next cycle and sets ack_pend for that cycle; a q_ready seen while ack_pend is high is not counted.
REQ-027 In FILL, each counted q_ready writes q_rdata into buf[wcnt] and increments wcnt, wrapping 3 to 0.
REQ-028 In FILL, if q_xfer_done arrives after the fourth counted word, the block sets tag, sets line_valid and goes to RESP.
REQ-029 In FILL, if q_xfer_done arrives after fewer than 4 counted words, line_valid stays 0 and the fill is reissued from wcnt=0 with q_valid low for one cycle; no req_ready is produced.
REQ-030 In WRITE, q_xfer_done moves the FSM to RESP.
REQ-031 A write that hits the buffer updates each byte of buf[req_addr[1:0]] whose req_wstrb bit is set, in the same cycle as it enters RESP.
REQ-032 RESP lasts one cycle: req_ready=1, and req_rdata is buf[req_addr[1:0]] for a read or 0 for a write; the FSM then returns to IDLE.
REQ-033 flush clears line_valid on the next edge, and a flush during FILL leaves line_valid 0 at fill completion.
REQ-034 The FILL response is still delivered when flush is asserted during FILL.
REQ-035 If flush and a hit read coincide in IDLE, the read is treated as a miss.
REQ-036 q_ce_ctrl equals cfg_ce_ctrl registered at the start of each transfer.

Reset
REQ-037 While rst is high the block holds: state IDLE, line_valid=0, wcnt=0, ack_pend=0, q_valid=0, q_ready_ack=0, req_ready=0, req_rdata=0, all q_ fields 0, buffer contents don't-care.
REQ-038 Assertion of rst in the middle of a transfer drops q_valid asynchronously.
REQ-039 After rst deasserts, the first request is always serviced as a miss.

Verification
REQ-040 Cold read 0x000102; the arbiter returns 0x1111, 0x2222, 0x3333, 0x4444, then done -> q_addr=0x000100, xfer_len=4, four q_ready_ack pulses, req_rdata=0x3333.
REQ-041 Read 0x000101 after the REQ-040 fill -> req_ready on the next cycle with 0x2222 and q_valid stays 0.
REQ-042 Write 0x000103, wdata=0xABCD, wstrb=2'b01 -> xfer_len=1 and req_ready after done; then read 0x000103 -> hit returning 0x44CD.
REQ-043 q_ready held high for 2 cycles -> one word counted and one q_ready_ack pulse.
REQ-044 q_xfer_done after 2 words -> fill reissued at the same address, single req_ready at the end.
REQ-045 rst pulsed during FILL -> q_valid=0 at once; next read of the same address misses and fills.
